// File: rtl/traincontroller_arb.sv
// rtl/traincontroller_arb.sv - round-robin common-section arbiter for NTRAIN trains
//
// Purpose: grants one shared track section to one train at a time using
// round-robin priority. It stops every other train that has approached, steers
// the switches to the owner, and latches a fault if the owner holds the section
// for too long.
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   s_app_i    approach sensor per train (level)
//   s_exit_i   exit sensor per train (level)
//   clear_i    fault acknowledge, only acted on in FAULT
//   dir_o      per-train drive, bits [2i+1:2i]: 01 forward, 00 stop
//   sw_o       switch steering, equals the owner index while owned, else 0
//   sw_en_o    high while the section is owned
//   busy_o     high in OCC
//   fault_o    high in FAULT
module traincontroller_arb #(
    parameter int  NTRAIN      = 3,
    parameter int  TIMEOUT_CYC = 1000,
    parameter int  TW          = 16,
    localparam int IW          = (NTRAIN > 2) ? $clog2(NTRAIN) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NTRAIN-1:0]   s_app_i,
    input  logic [NTRAIN-1:0]   s_exit_i,
    input  logic                clear_i,
    output logic [2*NTRAIN-1:0] dir_o,
    output logic [IW-1:0]       sw_o,
    output logic                sw_en_o,
    output logic                busy_o,
    output logic                fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OCC   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_TRAIN = IW'(NTRAIN - 1);

    state_t              state_q, state_d;
    logic [NTRAIN-1:0]   wait_q, wait_d;
    logic [NTRAIN-1:0]   app_q;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_owner_q, last_owner_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [NTRAIN-1:0]   rise;
    logic [NTRAIN-1:0]   owner_mask;
    logic                grant_found;
    logic [IW-1:0]       grant_idx;
    logic [IW-1:0]       scan_idx;

    // Round-robin scan. Offsets are visited from farthest to nearest so that the
    // nearest pending train after last_owner overwrites any farther candidate.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = NTRAIN; off >= 1; off--) begin
            scan_idx = IW'((int'(last_owner_q) + off) % NTRAIN);
            if (wait_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        owner_mask           = '0;
        owner_mask[owner_q]  = 1'b1;
        rise                 = s_app_i & ~app_q;
        // The owner re-triggering its own approach sensor must not queue a
        // second request behind itself.
        if (state_q == ST_OCC) begin
            rise = rise & ~owner_mask;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q | rise;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timer_d      = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    owner_d             = grant_idx;
                    last_owner_d        = grant_idx;
                    wait_d[grant_idx]   = 1'b0;
                    timer_d             = '0;
                    state_d             = ST_OCC;
                end
            end
            ST_OCC: begin
                timer_d = timer_q + 1'b1;
                // Exit is checked first so it wins over a same-cycle timeout.
                if (s_exit_i[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            app_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= LAST_TRAIN;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            app_q        <= s_app_i;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            timer_q      <= timer_d;
        end
    end

    // Moore outputs, decoded from registered state only.
    always_comb begin
        dir_o = '0;
        for (int i = 0; i < NTRAIN; i++) begin
            dir_o[2*i +: 2] = ((state_q == ST_FAULT) || wait_q[i]) ? 2'b00 : 2'b01;
        end
        busy_o  = (state_q == ST_OCC);
        fault_o = (state_q == ST_FAULT);
        sw_en_o = (state_q == ST_OCC);
        sw_o    = (state_q == ST_OCC) ? owner_q : '0;
    end

endmodule

// File: tb/tb_traincontroller_arb.sv
// tb/tb_traincontroller_arb.sv - directed vector bench for traincontroller_arb
module tb_traincontroller_arb;

    logic       clk;
    logic       reset;
    logic [2:0] s_app;
    logic [2:0] s_exit;
    logic       clear;
    logic [5:0] dir;
    logic [1:0] sw;
    logic       sw_en;
    logic       busy;
    logic       fault;

    int n_checks = 0;
    int n_pass   = 0;

    traincontroller_arb #(
        .NTRAIN     (3),
        .TIMEOUT_CYC(8),
        .TW         (16)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .s_app_i (s_app),
        .s_exit_i(s_exit),
        .clear_i (clear),
        .dir_o   (dir),
        .sw_o    (sw),
        .sw_en_o (sw_en),
        .busy_o  (busy),
        .fault_o (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] app;
        logic [2:0] ext;
        logic       clr;
        logic [5:0] dir;
        logic [1:0] sw;
        logic       en;
        logic       busy;
        logic       flt;
    } vec_t;

    // DIR patterns: train i stopped clears bit 2i.
    localparam logic [5:0] D_ALL  = 6'h15;
    localparam logic [5:0] D_S0   = 6'h14;
    localparam logic [5:0] D_S1   = 6'h11;
    localparam logic [5:0] D_S2   = 6'h05;
    localparam logic [5:0] D_S02  = 6'h04;
    localparam logic [5:0] D_S01  = 6'h10;
    localparam logic [5:0] D_STOP = 6'h00;

    vec_t vt[17];

    function automatic vec_t mk(logic r, logic [2:0] a, logic [2:0] e, logic c,
                                logic [5:0] d, logic [1:0] s, logic en, logic b, logic f);
        vec_t v;
        v.rst = r; v.app = a; v.ext = e; v.clr = c;
        v.dir = d; v.sw = s; v.en = en; v.busy = b; v.flt = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [5:0] d, input logic [1:0] s,
                             input logic en, input logic b, input logic f);
        check({tag, ".dir"},   32'(dir),   32'(d));
        check({tag, ".sw"},    32'(sw),    32'(s));
        check({tag, ".sw_en"}, 32'(sw_en), 32'(en));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] e, input logic c);
        reset = r; s_app = a; s_exit = e; clear = c;
        tick();
    endtask

    initial begin
        reset = 1'b1; s_app = '0; s_exit = '0; clear = 1'b0;

        // Single request, contention from reset, and round-robin fairness.
        vt[0]  = mk(1, 3'b000, 3'b000, 0, D_ALL, 0, 0, 0, 0);
        vt[1]  = mk(0, 3'b010, 3'b000, 0, D_S1,  0, 0, 0, 0);
        vt[2]  = mk(0, 3'b000, 3'b000, 0, D_ALL, 1, 1, 1, 0);
        vt[3]  = mk(0, 3'b000, 3'b010, 0, D_ALL, 0, 0, 0, 0);
        vt[4]  = mk(1, 3'b000, 3'b000, 0, D_ALL, 0, 0, 0, 0);
        vt[5]  = mk(0, 3'b101, 3'b000, 0, D_S02, 0, 0, 0, 0);
        vt[6]  = mk(0, 3'b101, 3'b000, 0, D_S2,  0, 1, 1, 0);
        vt[7]  = mk(0, 3'b101, 3'b000, 0, D_S2,  0, 1, 1, 0);
        vt[8]  = mk(0, 3'b101, 3'b001, 0, D_S2,  0, 0, 0, 0);
        vt[9]  = mk(0, 3'b101, 3'b000, 0, D_ALL, 2, 1, 1, 0);
        vt[10] = mk(0, 3'b100, 3'b000, 0, D_ALL, 2, 1, 1, 0);
        vt[11] = mk(0, 3'b111, 3'b000, 0, D_S01, 2, 1, 1, 0);
        vt[12] = mk(0, 3'b111, 3'b100, 0, D_S01, 0, 0, 0, 0);
        vt[13] = mk(0, 3'b111, 3'b000, 0, D_S1,  0, 1, 1, 0);
        vt[14] = mk(0, 3'b111, 3'b001, 0, D_S1,  0, 0, 0, 0);
        vt[15] = mk(0, 3'b111, 3'b000, 0, D_ALL, 1, 1, 1, 0);
        vt[16] = mk(0, 3'b111, 3'b010, 0, D_ALL, 0, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rst, vt[i].app, vt[i].ext, vt[i].clr);
            check_out($sformatf("vec%0d", i), vt[i].dir, vt[i].sw, vt[i].en, vt[i].busy, vt[i].flt);
        end

        // Timeout: train 1 owns, train 0 queues meanwhile, never an exit.
        drive(1, 3'b000, 3'b000, 0);
        drive(0, 3'b010, 3'b000, 0);
        drive(0, 3'b000, 3'b000, 0);
        check_out("to_grant", D_ALL, 1, 1, 1, 0);
        for (int n = 1; n <= 7; n++) begin
            drive(0, (n >= 3) ? 3'b001 : 3'b000, 3'b000, 0);
            check($sformatf("to_c%0d.fault", n), 32'(fault), 32'd0);
        end
        check("to_c7.dir", 32'(dir), 32'(D_S0));
        drive(0, 3'b001, 3'b000, 0);
        check_out("to_fault", D_STOP, 0, 0, 0, 1);
        drive(0, 3'b001, 3'b000, 0);
        check_out("to_hold", D_STOP, 0, 0, 0, 1);
        // CLEAR together with a fresh edge on train 2: both take effect.
        drive(0, 3'b101, 3'b000, 1);
        check_out("to_clear", D_S02, 0, 0, 0, 0);
        drive(0, 3'b101, 3'b000, 0);
        check_out("to_regrant", D_S0, 2, 1, 1, 0);

        // Exit on the same cycle the timer reaches its last value: exit wins.
        drive(1, 3'b000, 3'b000, 0);
        drive(0, 3'b010, 3'b000, 0);
        drive(0, 3'b000, 3'b000, 0);
        check_out("et_grant", D_ALL, 1, 1, 1, 0);
        for (int n = 1; n <= 7; n++) begin
            drive(0, 3'b000, 3'b000, 0);
        end
        check("et_pre.busy", 32'(busy), 32'd1);
        drive(0, 3'b000, 3'b010, 0);
        check_out("et_exit", D_ALL, 0, 0, 0, 0);
        drive(0, 3'b000, 3'b000, 0);
        check_out("et_after", D_ALL, 0, 0, 0, 0);

        // Reset mid-OCC with train 2 waiting and its sensor held high.
        drive(1, 3'b000, 3'b000, 0);
        drive(0, 3'b001, 3'b000, 0);
        drive(0, 3'b000, 3'b000, 0);
        check_out("rs_own0", D_ALL, 0, 1, 1, 0);
        drive(0, 3'b100, 3'b000, 0);
        check_out("rs_wait2", D_S2, 0, 1, 1, 0);
        drive(1, 3'b100, 3'b000, 0);
        check_out("rs_reset", D_ALL, 0, 0, 0, 0);
        drive(0, 3'b100, 3'b000, 0);
        check_out("rs_rereq", D_S2, 0, 0, 0, 0);
        drive(0, 3'b100, 3'b000, 0);
        check_out("rs_grant2", D_ALL, 2, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
